// File: rtl/game_pkg.sv
// Shared game-state codes, digit-entry FSM states and digit limits.
package game_pkg;

  localparam logic [3:0] ST_READY    = 4'b0010;
  localparam logic [3:0] ST_QUESTION = 4'b0011;
  localparam logic [3:0] ST_INPUT    = 4'b0100;
  localparam logic [3:0] ST_RES_OK   = 4'b0111;
  localparam logic [3:0] ST_RES_NG   = 4'b1000;

  localparam logic [3:0] DIGIT_MAX   = 4'd9;

  typedef enum logic [1:0] {IDLE, EDIT, COMMIT, LOCK} entry_state_e;

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces one active-low key. Reports the accepted level (1 = released)
// and a one-cycle press pulse on the accepted high->low edge.
module key_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic CLK,
  input  logic nRST,
  input  logic nKEY,
  output logic level,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flip;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= nKEY;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q counts consecutive samples that disagree with the accepted level
  always_comb begin
    flip    = (sync2_q != level_q) && (cnt_q == CNT_LAST);
    level_d = flip ? sync2_q : level_q;
    cnt_d   = ((sync2_q == level_q) || flip) ? '0 : cnt_q + 1'b1;
  end

  assign level = level_q;
  assign press = flip & ~sync2_q;

endmodule

// File: rtl/digit_entry_encoder.sv
// Player digit entry: three debounced keys edit a BCD digit and commit it while STATE==INPUT.
// Optional auto-repeat of UP/DN under macro DIGIT_AUTOREPEAT_EN.
module digit_entry_encoder
  import game_pkg::*;
#(
  parameter int DEB_CYCLES = 250000,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 10000000
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic [3:0] STATE,
  input  logic       nKEY_UP,
  input  logic       nKEY_DN,
  input  logic       nKEY_OK,
  output logic [3:0] DIN,
  output logic [3:0] ANS,
  output logic       ANS_VALID,
  output logic       EDITING
);

  logic up_lvl, dn_lvl, ok_lvl;
  logic up_press, dn_press, ok_press;
  logic up_step, dn_step;

  entry_state_e state_q, state_d;
  logic [3:0]   din_q, din_d, ans_q, ans_d;
  logic         ans_valid_q, ans_valid_d;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_up (
    .CLK(CLK), .nRST(nRST), .nKEY(nKEY_UP), .level(up_lvl), .press(up_press));
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dn (
    .CLK(CLK), .nRST(nRST), .nKEY(nKEY_DN), .level(dn_lvl), .press(dn_press));
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_ok (
    .CLK(CLK), .nRST(nRST), .nKEY(nKEY_OK), .level(ok_lvl), .press(ok_press));

  logic unused_lvl;
  assign unused_lvl = ok_lvl;

`ifdef DIGIT_AUTOREPEAT_EN
  localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int RW      = $clog2(REP_MAX + 1);

  logic          rep_act_q, rep_act_d, rep_up_q, rep_up_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_held, rep_tick;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rep_act_q <= 1'b0;
      rep_up_q  <= 1'b0;
      rep_cnt_q <= '0;
    end else begin
      rep_act_q <= rep_act_d;
      rep_up_q  <= rep_up_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

  assign rep_held = rep_up_q ? ~up_lvl : ~dn_lvl;
  assign rep_tick = rep_act_q && rep_held && (rep_cnt_q == '0) && (state_q == EDIT);

  // A fresh press re-arms the timer; UP+DN together or a release cancels it
  always_comb begin
    rep_act_d = rep_act_q;
    rep_up_d  = rep_up_q;
    rep_cnt_d = rep_cnt_q;
    if (state_q != EDIT || STATE != ST_INPUT || ok_press) begin
      rep_act_d = 1'b0;
    end else if (up_press ^ dn_press) begin
      rep_act_d = 1'b1;
      rep_up_d  = up_press;
      rep_cnt_d = RW'(REP_DELAY - 1);
    end else if ((up_press & dn_press) || !rep_held) begin
      rep_act_d = 1'b0;
    end else if (rep_act_q) begin
      rep_cnt_d = (rep_cnt_q == '0) ? RW'(REP_PERIOD - 1) : rep_cnt_q - 1'b1;
    end
  end

  assign up_step = up_press | (rep_tick &  rep_up_q);
  assign dn_step = dn_press | (rep_tick & ~rep_up_q);
`else
  logic unused_rep;
  assign unused_rep = ^{REP_DELAY[31:0], REP_PERIOD[31:0], up_lvl, dn_lvl};
  assign up_step    = up_press;
  assign dn_step    = dn_press;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      din_q       <= '0;
      ans_q       <= '0;
      ans_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      din_q       <= din_d;
      ans_q       <= ans_d;
      ans_valid_q <= ans_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (STATE != ST_INPUT) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = EDIT;
        EDIT:    if (ok_press) state_d = COMMIT;
        COMMIT:  state_d = LOCK;
        LOCK:    state_d = LOCK;
        default: state_d = IDLE;
      endcase
    end
  end

  // OK outranks UP/DN; UP and DN in the same cycle cancel
  always_comb begin
    din_d       = din_q;
    ans_d       = ans_q;
    ans_valid_d = 1'b0;
    if (STATE != ST_INPUT || state_q == IDLE) begin
      din_d = '0;
    end else if (state_q == EDIT && !ok_press) begin
      if (up_step && !dn_step)      din_d = (din_q == DIGIT_MAX) ? 4'd0 : din_q + 4'd1;
      else if (dn_step && !up_step) din_d = (din_q == 4'd0) ? DIGIT_MAX : din_q - 4'd1;
    end else if (state_q == COMMIT) begin
      ans_d       = din_q;
      ans_valid_d = 1'b1;
    end
  end

  always_comb begin
    EDITING   = (state_q == EDIT);
    DIN       = din_q;
    ANS       = ans_q;
    ANS_VALID = ans_valid_q;
  end

endmodule

// File: tb/tb_digit_entry_encoder.sv
// Directed bench for digit_entry_encoder with a cycle-level reference model compared every cycle.
module tb_digit_entry_encoder;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam logic [3:0] S_INPUT = 4'b0100;
  localparam logic [3:0] S_READY = 4'b0010;
  localparam int P_OFF = 0, P_EDIT = 1, P_COMMIT = 2, P_LOCK = 3;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic [3:0] STATE = S_READY;
  logic       nKEY_UP = 1'b1, nKEY_DN = 1'b1, nKEY_OK = 1'b1;
  logic [3:0] DIN, ANS;
  logic       ANS_VALID, EDITING;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  digit_entry_encoder #(.DEB_CYCLES(DEB), .REP_DELAY(RD), .REP_PERIOD(RP)) dut (
    .CLK(CLK), .nRST(nRST), .STATE(STATE),
    .nKEY_UP(nKEY_UP), .nKEY_DN(nKEY_DN), .nKEY_OK(nKEY_OK),
    .DIN(DIN), .ANS(ANS), .ANS_VALID(ANS_VALID), .EDITING(EDITING));

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  int hist[3][DEB+2];
  bit lvl[3];
  int phase, m_din, m_ans, ncyc, rep_dir, rep_since;
  bit m_valid;

  function automatic bit pin(int k);
    case (k)
      0:       return nKEY_UP;
      1:       return nKEY_DN;
      default: return nKEY_OK;
    endcase
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 3; k++) begin
      lvl[k] = 1'b1;
      for (int j = 0; j < DEB + 2; j++) hist[k][j] = 1;
    end
    phase = P_OFF; m_din = 0; m_ans = 0; m_valid = 1'b0;
    ncyc = 0; rep_dir = 0; rep_since = 0;
  endtask

  // A key level is accepted once the DEB pin samples taken 2..DEB+1 edges ago all disagree with it
  task automatic m_step();
    bit pr[3], held[3], all0, all1, up, dn, ok;
    ncyc++;
    for (int k = 0; k < 3; k++) begin
      held[k] = !lvl[k];
      for (int j = DEB + 1; j > 0; j--) hist[k][j] = hist[k][j-1];
      hist[k][0] = int'(pin(k));
      all0 = 1'b1; all1 = 1'b1;
      for (int j = 2; j <= DEB + 1; j++) begin
        if (hist[k][j] != 0) all0 = 1'b0;
        if (hist[k][j] != 1) all1 = 1'b0;
      end
      pr[k] = lvl[k] && all0;
      if (lvl[k] && all0) lvl[k] = 1'b0;
      else if (!lvl[k] && all1) lvl[k] = 1'b1;
    end
    up = pr[0]; dn = pr[1]; ok = pr[2];
`ifdef DIGIT_AUTOREPEAT_EN
    if (phase == P_EDIT && STATE == S_INPUT && rep_dir != 0 && held[rep_dir-1] &&
        ncyc - rep_since >= RD && (ncyc - rep_since - RD) % RP == 0) begin
      if (rep_dir == 1) up = 1'b1; else dn = 1'b1;
    end
    if (phase != P_EDIT || STATE != S_INPUT || ok) rep_dir = 0;
    else if (pr[0] != pr[1]) begin rep_dir = pr[0] ? 1 : 2; rep_since = ncyc; end
    else if (pr[0] && pr[1]) rep_dir = 0;
`endif
    m_valid = 1'b0;
    if (STATE != S_INPUT) begin
      phase = P_OFF; m_din = 0;
    end else begin
      case (phase)
        P_OFF:    begin phase = P_EDIT; m_din = 0; end
        P_EDIT: begin
          if (ok) phase = P_COMMIT;
          else if (up && !dn) m_din = (m_din + 1) % 10;
          else if (dn && !up) m_din = (m_din + 9) % 10;
        end
        P_COMMIT: begin m_ans = m_din; m_valid = 1'b1; phase = P_LOCK; end
        default:  ;
      endcase
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge CLK or negedge nRST);
      if (!nRST) m_reset(); else m_step();
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge CLK);
    if (chk_on && nRST === 1'b1) begin
      chk("model_DIN", DIN, 4'(m_din));
      chk("model_ANS", ANS, 4'(m_ans));
      chk("model_ANS_VALID", {3'b0, ANS_VALID}, {3'b0, m_valid});
      chk("model_EDITING", {3'b0, EDITING}, {3'b0, phase == P_EDIT});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0:       nKEY_UP = v;
      1:       nKEY_DN = v;
      default: nKEY_OK = v;
    endcase
  endtask

  task automatic press(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      set_key(k, 1'b0); tick(6);
      set_key(k, 1'b1); tick(8);
    end
  endtask

  initial begin
    bit got;
    tick(3);
    chk("rst_DIN", DIN, 4'd0);
    chk("rst_EDITING", {3'b0, EDITING}, 4'd0);
    nRST = 1'b1; chk_on = 1'b1;
    tick(2);

    STATE = S_INPUT; tick(2);
    chk("enter_EDITING", {3'b0, EDITING}, 4'd1);

    // 3-cycle glitch is rejected
    nKEY_UP = 1'b0; tick(3); nKEY_UP = 1'b1; tick(8);
    chk("glitch_DIN", DIN, 4'd0);

    // a 10-cycle press lands exactly 6 cycles after the falling edge
    nKEY_UP = 1'b0; tick(5);
    chk("deb_pre_DIN", DIN, 4'd0);
    tick(1);
    chk("deb_lat_DIN", DIN, 4'd1);
    tick(4); nKEY_UP = 1'b1; tick(8);

    press(0, 9);
    chk("wrap_up_DIN", DIN, 4'd0);
    press(1, 1);
    chk("wrap_dn_DIN", DIN, 4'd9);
    press(1, 2);
    chk("pre_commit_DIN", DIN, 4'd7);

    nKEY_OK = 1'b0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if (ANS_VALID === 1'b1) got = 1'b1;
    end
    chk("commit_pulse", {3'b0, got}, 4'd1);
    chk("commit_ANS", ANS, 4'd7);
    tick(1);
    chk("commit_pulse_end", {3'b0, ANS_VALID}, 4'd0);
    nKEY_OK = 1'b1; tick(8);
    press(0, 2);
    chk("lock_DIN", DIN, 4'd7);
    chk("lock_EDITING", {3'b0, EDITING}, 4'd0);

    STATE = S_READY; tick(2); STATE = S_INPUT; tick(2);
    press(0, 3);
    chk("prio_pre_DIN", DIN, 4'd3);
    nKEY_UP = 1'b0; nKEY_OK = 1'b0; tick(6);
    nKEY_UP = 1'b1; nKEY_OK = 1'b1; tick(10);
    chk("prio_ANS", ANS, 4'd3);
    chk("prio_DIN", DIN, 4'd3);
    STATE = S_READY; tick(2);
    chk("exit_DIN", DIN, 4'd0);
    chk("exit_EDITING", {3'b0, EDITING}, 4'd0);
    chk("exit_ANS", ANS, 4'd3);

    // long hold: repeat steps only when auto-repeat is built in
    STATE = S_INPUT; tick(2);
    nKEY_UP = 1'b0; tick(30); nKEY_UP = 1'b1; tick(10);
`ifdef DIGIT_AUTOREPEAT_EN
    chk("hold_DIN", DIN, 4'd3);
`else
    chk("hold_DIN", DIN, 4'd1);
`endif

    // key already held when EDIT is entered yields no step
    STATE = S_READY; nKEY_DN = 1'b0; tick(10);
    STATE = S_INPUT; tick(10);
    chk("held_entry_DIN", DIN, 4'd0);
    nKEY_DN = 1'b1; tick(10);
    chk("held_release_DIN", DIN, 4'd0);

    // async reset mid-debounce
    press(0, 2);
    nKEY_UP = 1'b0; tick(3);
    #2 nRST = 1'b0;
    #1;
    chk("async_DIN", DIN, 4'd0);
    chk("async_ANS", ANS, 4'd0);
    chk("async_VALID", {3'b0, ANS_VALID}, 4'd0);
    chk("async_EDITING", {3'b0, EDITING}, 4'd0);
    tick(2); nKEY_UP = 1'b1; nRST = 1'b1; tick(12);
    chk("post_rst_DIN", DIN, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
